// File: rtl/td_pkg.sv
// Shared types and default widths for the target_detect block.
package td_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } td_state_e;

  localparam int          TD_AMP_W        = 12;
  localparam int          TD_RNG_W        = 10;
  localparam int          TD_AZ_W         = 9;
  localparam int          TD_HIST_N       = 5;
  localparam int          TD_HIT_M        = 3;
  localparam logic [15:0] TD_SCAN_TIMEOUT = 16'd4096;
  localparam logic [9:0]  TD_MIN_RANGE    = 10'd8;

endpackage

// File: rtl/target_detect_if.sv
// Echo-stream / lock-tracking bus; slave = detector side, master = stream source and consumer.
// Handshake: scan_start/scan_end are one-cycle pulses, echo_valid qualifies one sample per cycle
// (no backpressure), and data_valid is a one-cycle pulse carrying fresh tgt_* coordinates.
interface target_detect_if #(
  parameter int AMP_W = 12,
  parameter int RNG_W = 10,
  parameter int AZ_W  = 9,
  parameter int CNT_W = 3
);
  logic             scan_start;
  logic             scan_end;
  logic [AZ_W-1:0]  azimuth;
  logic             echo_valid;
  logic [AMP_W-1:0] echo_amp;
  logic [RNG_W-1:0] echo_range;
  logic [AMP_W-1:0] thresh;
  logic             target_found;
  logic             data_valid;
  logic [RNG_W-1:0] tgt_range;
  logic [AZ_W-1:0]  tgt_az;
  logic [AMP_W-1:0] tgt_amp;
  logic [CNT_W-1:0] hit_count;

  modport slave (
    input  scan_start, scan_end, azimuth, echo_valid, echo_amp, echo_range, thresh,
    output target_found, data_valid, tgt_range, tgt_az, tgt_amp, hit_count
  );

  modport master (
    output scan_start, scan_end, azimuth, echo_valid, echo_amp, echo_range, thresh,
    input  target_found, data_valid, tgt_range, tgt_az, tgt_amp, hit_count
  );
endinterface

// File: rtl/target_detect_mofn_window.sv
// M-of-N persistence window: N-deep hit history, registered popcount and found flag.
module mofn_window #(
  parameter int HIST_N = 5,
  parameter int HIT_M  = 3,
  parameter int CNT_W  = $clog2(HIST_N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             hit,
  output logic [CNT_W-1:0] count,
  output logic             found
);

  logic [HIST_N-1:0] hist;
  logic [CNT_W-1:0]  pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < HIST_N; i++) begin
      pop = pop + CNT_W'(hist[i]);
    end
  end

  // count/found trail the history shift by one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      count <= '0;
      found <= 1'b0;
    end else begin
      if (shift_en) begin
        hist <= (hist << 1) | HIST_N'(hit);
      end
      count <= pop;
      found <= (pop >= CNT_W'(HIT_M));
    end
  end

endmodule

// File: rtl/target_detect.sv
// Per-scan peak detector with M-of-N persistence; TD_MIN_RANGE_GATE_EN enables the near-range clutter gate.
module target_detect
  import td_pkg::*;
#(
  parameter int          AMP_W        = TD_AMP_W,
  parameter int          RNG_W        = TD_RNG_W,
  parameter int          AZ_W         = TD_AZ_W,
  parameter int          HIST_N       = TD_HIST_N,
  parameter int          HIT_M        = TD_HIT_M,
  parameter logic [15:0] SCAN_TIMEOUT = TD_SCAN_TIMEOUT,
  parameter logic [RNG_W-1:0] MIN_RANGE = RNG_W'(TD_MIN_RANGE)
) (
  input  logic            clk,
  input  logic            reset,
  target_detect_if.slave  bus,
  output td_state_e       state_dbg
);

  localparam int CNT_W = $clog2(HIST_N + 1);

`ifdef TD_MIN_RANGE_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  td_state_e        state;
  logic             peak_valid;
  logic [AMP_W-1:0] peak_amp;
  logic [RNG_W-1:0] peak_rng;
  logic [AZ_W-1:0]  peak_az;
  logic [15:0]      wd;
  logic             rep_hit;
  logic             data_valid;
  logic [RNG_W-1:0] tgt_range;
  logic [AZ_W-1:0]  tgt_az;
  logic [AMP_W-1:0] tgt_amp;
  logic             qualify;
  logic             take;
  logic [CNT_W-1:0] hit_count;
  logic             target_found;

  always_comb begin
    qualify = bus.echo_valid && (bus.echo_amp >= bus.thresh) &&
              (!GATE_EN || (bus.echo_range >= MIN_RANGE));
    // strict compare: an equal later sample never displaces the earlier peak
    take    = qualify && (!peak_valid || (bus.echo_amp > peak_amp));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_rng   <= '0;
      peak_az    <= '0;
      wd         <= '0;
      rep_hit    <= 1'b0;
      data_valid <= 1'b0;
      tgt_range  <= '0;
      tgt_az     <= '0;
      tgt_amp    <= '0;
    end else begin
      data_valid <= rep_hit;
      rep_hit    <= 1'b0;
      if (rep_hit) begin
        tgt_range <= peak_rng;
        tgt_az    <= peak_az;
        tgt_amp   <= peak_amp;
      end
      case (state)
        IDLE: begin
          if (bus.scan_start) begin
            state      <= SCAN;
            peak_valid <= 1'b0;
            peak_amp   <= '0;
            wd         <= '0;
          end
        end
        SCAN: begin
          wd <= wd + 16'd1;
          if (bus.scan_end) begin
            state <= REPORT;
            if (take) begin
              peak_valid <= 1'b1;
              peak_amp   <= bus.echo_amp;
              peak_rng   <= bus.echo_range;
              peak_az    <= bus.azimuth;
            end
          end else if (wd == SCAN_TIMEOUT - 16'd1) begin
            state      <= REPORT;
            peak_valid <= 1'b0;
          end else if (bus.scan_start) begin
            peak_valid <= 1'b0;
            peak_amp   <= '0;
            wd         <= '0;
          end else if (take) begin
            peak_valid <= 1'b1;
            peak_amp   <= bus.echo_amp;
            peak_rng   <= bus.echo_range;
            peak_az    <= bus.azimuth;
          end
        end
        REPORT: begin
          rep_hit <= peak_valid;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mofn_window #(
    .HIST_N (HIST_N),
    .HIT_M  (HIT_M),
    .CNT_W  (CNT_W)
  ) u_mofn (
    .clk      (clk),
    .reset    (reset),
    .shift_en (state == REPORT),
    .hit      (peak_valid),
    .count    (hit_count),
    .found    (target_found)
  );

  assign bus.target_found = target_found;
  assign bus.data_valid   = data_valid;
  assign bus.tgt_range    = tgt_range;
  assign bus.tgt_az       = tgt_az;
  assign bus.tgt_amp      = tgt_amp;
  assign bus.hit_count    = hit_count;
  assign state_dbg        = state;

endmodule

// File: tb/tb_target_detect.sv
// Directed bench for target_detect: peak capture, thresholds, M-of-N persistence, timeout, abort, reset.
module tb_target_detect;
  import td_pkg::*;

  logic      clk;
  logic      reset;
  td_state_e state_dbg;

  target_detect_if #(.AMP_W(12), .RNG_W(10), .AZ_W(9), .CNT_W(3)) bus ();

  target_detect dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dv_total = 0;
  int dv_consec = 0;
  logic dv_prev = 1'b0;

  int         n_echo;
  logic [11:0] ea [0:7];
  logic [9:0]  er [0:7];
  logic [8:0]  ez [0:7];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_total++;
      if (dv_prev) dv_consec++;
    end
    dv_prev = (bus.data_valid === 1'b1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #10 reset = 1'b0;
    tick();
  endtask

  task automatic set_echo(input int i, input int amp, input int rng, input int az);
    ea[i] = 12'(amp);
    er[i] = 10'(rng);
    ez[i] = 9'(az);
  endtask

  task automatic run_scan(output logic dv_early, output logic dv, output logic found_early);
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    for (int i = 0; i < n_echo; i++) begin
      bus.echo_valid = 1'b1;
      bus.echo_amp   = ea[i];
      bus.echo_range = er[i];
      bus.azimuth    = ez[i];
      tick();
    end
    bus.echo_valid = 1'b0;
    bus.scan_end   = 1'b1;
    tick();
    bus.scan_end = 1'b0;
    tick();
    dv_early    = bus.data_valid;
    found_early = bus.target_found;
    tick();
    dv = bus.data_valid;
    tick();
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.target_found, bus.data_valid, bus.tgt_range, bus.tgt_az, bus.tgt_amp, bus.hit_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs expected all zero");
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_persistence();
    logic dve, dv, fe;
    int exp_cnt [3] = '{1, 2, 3};
    n_echo = 1;
    set_echo(0, 150, 42, 90);
    for (int s = 0; s < 3; s++) begin
      run_scan(dve, dv, fe);
      n_checks++;
      if (dve !== 1'b0 || dv !== 1'b1) begin
        n_fail++;
        $display("FAIL persist_dv_latency scan%0d: got early=%0b k2=%0b expected early=0 k2=1", s, dve, dv);
      end
      n_checks++;
      if (bus.hit_count !== 3'(exp_cnt[s])) begin
        n_fail++;
        $display("FAIL persist_hit_count scan%0d: got %0d expected %0d", s, bus.hit_count, exp_cnt[s]);
      end
      n_checks++;
      if (fe !== 1'b0 || bus.target_found !== (s == 2)) begin
        n_fail++;
        $display("FAIL persist_found scan%0d: got early=%0b after=%0b expected early=0 after=%0b",
                 s, fe, bus.target_found, (s == 2));
      end
    end
    n_checks++;
    if (bus.tgt_range !== 10'd42 || bus.tgt_az !== 9'd90 || bus.tgt_amp !== 12'd150) begin
      n_fail++;
      $display("FAIL persist_coords: got r=%0d az=%0d amp=%0d expected r=42 az=90 amp=150",
               bus.tgt_range, bus.tgt_az, bus.tgt_amp);
    end
  endtask

  task automatic test_peak_tie();
    logic dve, dv, fe;
    n_echo = 3;
    set_echo(0, 120, 10, 11);
    set_echo(1, 200, 20, 21);
    set_echo(2, 200, 30, 31);
    run_scan(dve, dv, fe);
    check_val("tie_dv", dv, 1);
    n_checks++;
    if (bus.tgt_amp !== 12'd200 || bus.tgt_range !== 10'd20 || bus.tgt_az !== 9'd21) begin
      n_fail++;
      $display("FAIL tie_coords: got amp=%0d r=%0d az=%0d expected amp=200 r=20 az=21",
               bus.tgt_amp, bus.tgt_range, bus.tgt_az);
    end
    check_val("tie_hit_count", bus.hit_count, 4);
  endtask

  task automatic test_threshold();
    logic dve, dv, fe;
    n_echo = 1;
    set_echo(0, 99, 60, 61);
    run_scan(dve, dv, fe);
    check_val("thresh_below_dv", dv, 0);
    check_val("thresh_below_hold_amp", bus.tgt_amp, 200);
    check_val("thresh_below_hit_count", bus.hit_count, 4);
    set_echo(0, 100, 55, 56);
    run_scan(dve, dv, fe);
    check_val("thresh_equal_dv", dv, 1);
    check_val("thresh_equal_amp", bus.tgt_amp, 100);
    check_val("thresh_equal_range", bus.tgt_range, 55);
    check_val("thresh_equal_hit_count", bus.hit_count, 4);
  endtask

  task automatic test_miss_decay();
    logic dve, dv, fe;
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    set_echo(0, 150, 42, 90);
    for (int s = 0; s < 5; s++) begin
      n_echo = pat[s] ? 1 : 0;
      run_scan(dve, dv, fe);
    end
    check_val("decay_locked_count", bus.hit_count, 3);
    check_val("decay_locked_found", bus.target_found, 1);
    n_echo = 0;
    for (int s = 0; s < 3; s++) begin
      run_scan(dve, dv, fe);
      check_val($sformatf("decay_miss%0d_dv", s), dv, 0);
      check_val($sformatf("decay_miss%0d_count", s), bus.hit_count, 2);
      check_val($sformatf("decay_miss%0d_found", s), bus.target_found, 0);
    end
  endtask

  task automatic test_timeout();
    int dv_before;
    int cycles;
    dv_before = dv_total;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.echo_valid = 1'b1;
    bus.echo_amp   = 12'd400;
    bus.echo_range = 10'd12;
    bus.azimuth    = 9'd13;
    tick();
    bus.echo_valid = 1'b0;
    cycles = 1;
    while (state_dbg != REPORT && cycles < 5000) begin
      tick();
      cycles++;
    end
    check_val("timeout_cycles", cycles, 4096);
    tick();
    tick();
    check_val("timeout_state_idle", state_dbg, IDLE);
    check_val("timeout_hit_count", bus.hit_count, 1);
    check_val("timeout_no_dv", dv_total - dv_before, 0);
    check_val("timeout_hold_amp", bus.tgt_amp, 150);
  endtask

  task automatic test_abort();
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.echo_valid = 1'b1;
    bus.echo_amp   = 12'd500;
    bus.echo_range = 10'd7;
    bus.azimuth    = 9'd8;
    tick();
    bus.echo_valid = 1'b0;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    // final echo lands in the same cycle as scan_end
    bus.echo_valid = 1'b1;
    bus.echo_amp   = 12'd130;
    bus.echo_range = 10'd9;
    bus.azimuth    = 9'd3;
    bus.scan_end   = 1'b1;
    tick();
    bus.echo_valid = 1'b0;
    bus.scan_end   = 1'b0;
    tick();
    tick();
    check_val("abort_dv", bus.data_valid, 1);
    check_val("abort_amp", bus.tgt_amp, 130);
    check_val("abort_range", bus.tgt_range, 9);
    check_val("abort_hit_count", bus.hit_count, 1);
    tick();
  endtask

  task automatic test_reset_midscan();
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.echo_valid = 1'b1;
    bus.echo_amp   = 12'd250;
    bus.echo_range = 10'd20;
    bus.azimuth    = 9'd4;
    tick();
    bus.echo_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.target_found, bus.data_valid, bus.tgt_range, bus.tgt_az, bus.tgt_amp, bus.hit_count} !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset_outputs: got amp=%0d cnt=%0d expected all zero", bus.tgt_amp, bus.hit_count);
    end
    check_val("midscan_reset_state", state_dbg, IDLE);
    #10 reset = 1'b0;
    tick();
    tick();
    check_val("midscan_no_report", bus.data_valid, 0);
  endtask

  task automatic test_range_gate();
    logic dve, dv, fe;
    n_echo = 1;
    set_echo(0, 300, 5, 6);
    run_scan(dve, dv, fe);
`ifdef TD_MIN_RANGE_GATE_EN
    check_val("gate_dv", dv, 0);
    check_val("gate_hit_count", bus.hit_count, 0);
    check_val("gate_range", bus.tgt_range, 0);
`else
    check_val("gate_dv", dv, 1);
    check_val("gate_hit_count", bus.hit_count, 1);
    check_val("gate_range", bus.tgt_range, 5);
`endif
  endtask

  task automatic test_pulse_totals();
    // 3 + 1 + 1 + 3 + 1 pulses from earlier scans, plus the gate scan when ungated
`ifdef TD_MIN_RANGE_GATE_EN
    check_val("dv_total", dv_total, 9);
`else
    check_val("dv_total", dv_total, 10);
`endif
    check_val("dv_never_consecutive", dv_consec, 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.scan_start = 1'b0;
    bus.scan_end   = 1'b0;
    bus.echo_valid = 1'b0;
    bus.echo_amp   = '0;
    bus.echo_range = '0;
    bus.azimuth    = '0;
    bus.thresh     = 12'd100;
    n_echo         = 0;
    test_reset();
    test_persistence();
    test_peak_tie();
    test_threshold();
    test_miss_decay();
    test_timeout();
    test_abort();
    test_reset_midscan();
    test_range_gate();
    tick();
    test_pulse_totals();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
